// File: rtl/say_arbiter.sv
// say_arbiter: round-robin merge of NREQ one-entry request slots onto a single
// credited downstream say port, with a drain/quiesce handshake.
module say_arbiter #(
    parameter int NREQ    = 4,
    parameter int METH_W  = 6,
    parameter int V_W     = 4,
    parameter int CREDITS = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        req__ENA,
    input  logic [NREQ*METH_W-1:0] req_meth,
    input  logic [NREQ*V_W-1:0]    req_v,
    output logic [NREQ-1:0]        req__RDY,
    output logic                   say__ENA,
    output logic [METH_W-1:0]      say_meth,
    output logic [V_W-1:0]         say_v,
    input  logic                   say__RDY,
    output logic                   rule_enable,
    input  logic                   rule_ready,
    output logic [2:0]             grant_id,
    input  logic                   drain_req,
    output logic                   drain_done,
    output logic [15:0]            issued
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_DRAINED = 2'd2;

    logic [NREQ-1:0]   full_r;
    logic [NREQ-1:0]   full_next_s;
    logic [METH_W-1:0] meth_r [NREQ];
    logic [V_W-1:0]    v_r [NREQ];
    logic [2:0]        in_flight_r;
    logic [2:0]        in_flight_next_s;
    logic [2:0]        last_grant_r;
    logic [1:0]        state_r;
    logic [1:0]        state_next_s;
    logic [15:0]       issued_r;

    logic [NREQ-1:0]   accept_s;
    logic [NREQ-1:0]   load_s;
    logic [3:0]        pick_s;
    logic [2:0]        grant_s;
    logic              any_full_s;
    logic              say_fire_s;
    logic              rule_fire_s;
    logic [METH_W-1:0] meth_sel_s;
    logic [V_W-1:0]    v_sel_s;

    // Returns {found, index} of the first full slot at or after last+1, wrapping.
    // Scanning the offsets from farthest to nearest lets the nearest hit win.
    function automatic logic [3:0] rr_pick(input logic [NREQ-1:0] full,
                                           input logic [2:0]      last);
        logic [3:0] pick;
        pick = 4'd0;
        for (int k = NREQ; k >= 1; k--) begin
            for (int j = 0; j < NREQ; j++) begin
                if (full[j] && (j == ((int'(last) + k) % NREQ))) begin
                    pick = {1'b1, 3'(j)};
                end else begin
                    pick = pick;
                end
            end
        end
        return pick;
    endfunction

    // Slot acceptance, arbitration and the issue/respond gates
    always_comb begin
        accept_s    = ~full_r & {NREQ{(state_r == ST_RUN) && !RST}};
        load_s      = req__ENA & accept_s;
        pick_s      = rr_pick(full_r, last_grant_r);
        any_full_s  = pick_s[3];
        grant_s     = pick_s[2:0];
        say_fire_s  = any_full_s && (in_flight_r < 3'(CREDITS)) && say__RDY
                      && (state_r != ST_DRAINED) && !RST;
        rule_fire_s = rule_ready && (in_flight_r != 3'd0) && !RST;
    end

    // Payload mux of the winning slot; all-zero when nothing is issued
    always_comb begin
        meth_sel_s = '0;
        v_sel_s    = '0;
        for (int i = 0; i < NREQ; i++) begin
            meth_sel_s = meth_sel_s
                       | ({METH_W{say_fire_s && (grant_s == 3'(i))}} & meth_r[i]);
            v_sel_s    = v_sel_s
                       | ({V_W{say_fire_s && (grant_s == 3'(i))}} & v_r[i]);
        end
    end

    // Next slot occupancy and credit count
    always_comb begin
        full_next_s = full_r;
        for (int i = 0; i < NREQ; i++) begin
            if (say_fire_s && (grant_s == 3'(i))) begin
                full_next_s[i] = 1'b0;
            end else if (load_s[i]) begin
                full_next_s[i] = 1'b1;
            end else begin
                full_next_s[i] = full_r[i];
            end
        end
        case ({say_fire_s, rule_fire_s})
            2'b10:   in_flight_next_s = in_flight_r + 3'd1;
            2'b01:   in_flight_next_s = in_flight_r - 3'd1;
            default: in_flight_next_s = in_flight_r;
        endcase
    end

    // Drain FSM; completion looks at the post-update occupancy and credits
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (drain_req) state_next_s = ST_DRAIN;
                else           state_next_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (!drain_req)
                    state_next_s = ST_RUN;
                else if ((full_next_s == '0) && (in_flight_next_s == 3'd0))
                    state_next_s = ST_DRAINED;
                else
                    state_next_s = ST_DRAIN;
            end
            ST_DRAINED: begin
                if (!drain_req) state_next_s = ST_RUN;
                else            state_next_s = ST_DRAINED;
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // Control state registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            full_r       <= '0;
            in_flight_r  <= 3'd0;
            last_grant_r <= 3'(NREQ - 1);
            state_r      <= ST_RUN;
            issued_r     <= 16'd0;
        end else begin
            full_r      <= full_next_s;
            in_flight_r <= in_flight_next_s;
            state_r     <= state_next_s;
            if (say_fire_s) begin
                last_grant_r <= grant_s;
                issued_r     <= issued_r + 16'd1;
            end
        end
    end

    // Slot payload capture; contents are don't-care while the slot is empty
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NREQ; i++) begin
            if (load_s[i]) begin
                meth_r[i] <= req_meth[i*METH_W +: METH_W];
                v_r[i]    <= req_v[i*V_W +: V_W];
            end
        end
    end

    assign req__RDY    = accept_s;
    assign say__ENA    = say_fire_s;
    assign say_meth    = meth_sel_s;
    assign say_v       = v_sel_s;
    assign grant_id    = say_fire_s ? grant_s : 3'd0;
    assign rule_enable = rule_fire_s;
    assign drain_done  = (state_r == ST_DRAINED) && !RST;
    assign issued      = issued_r;

endmodule
